// File: rtl/sr_coupling_pkg.sv
// sr_coupling_pkg: constants, saturation widths and FSM encodings
// shared by the SR coupling scheduler and its coupling engine.
package sr_coupling_pkg;

  localparam int FRAC = 14;
  localparam int ONE = 1 << FRAC;
  localparam int DEFAULT_THRESH = 12;
  localparam int DEFAULT_SCALE = 114;

  // prod saturates to this many bits
  localparam int PROD_W = 32;
  localparam logic [PROD_W-1:0] PROD_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    PUBLISH
  } state_t;

  typedef enum logic [1:0] {
    DIFF,
    SQ,
    SCALE,
    CLAMP
  } phase_t;

endpackage

// File: rtl/sr_coupling_scheduler_engine.sv
// coupling_engine: registered DIFF/SQ/SCALE datapath, CLAMP is
// combinational. Ports: phase enables, operands, det and c results.
module coupling_engine
  import sr_coupling_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_diff,
  input  logic                    en_sq,
  input  logic                    en_scale,
  input  logic signed [WIDTH-1:0] osc,
  input  logic signed [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0]        thresh,
  input  logic [WIDTH-1:0]        scale,
  output logic [WIDTH-1:0]        det,
  output logic [WIDTH-1:0]        c
);

  localparam logic [WIDTH:0] DET_MAX =
    {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic [PROD_W-1:0] ONE_P = PROD_W'(ONE);

  logic signed [WIDTH:0] diff;
  logic [WIDTH:0]        mag;
  logic [WIDTH-1:0]      det_n;
  logic [2*WIDTH-1:0]    sq;
  logic [2*WIDTH-1:0]    sq_n;
  logic [3*WIDTH-1:0]    full;
  logic [PROD_W-1:0]     prod;
  logic [PROD_W-1:0]     prod_n;
  logic                  zero_c;

  always_comb begin
    diff = (WIDTH+1)'(osc) - (WIDTH+1)'(sr);
    mag = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    det_n = (mag > DET_MAX) ? DET_MAX[WIDTH-1:0]
                            : mag[WIDTH-1:0];
    sq_n = (2*WIDTH)'(det) * (2*WIDTH)'(det);
    full = (3*WIDTH)'(sq) * (3*WIDTH)'(scale);
    prod_n = (|full[3*WIDTH-1:PROD_W]) ? PROD_MAX
                                       : full[PROD_W-1:0];
    // prod >= ONE would go negative: clamp to zero
    if (zero_c || prod >= ONE_P) c = '0;
    else c = WIDTH'(ONE_P - prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det <= '0;
      sq <= '0;
      zero_c <= 1'b0;
      prod <= '0;
    end else begin
      if (en_diff) det <= det_n;
      if (en_sq) begin
        sq <= sq_n;
        zero_c <= (det > thresh);
      end
      if (en_scale) prod <= prod_n;
    end
  end

endmodule

// File: rtl/sr_coupling_scheduler.sv
// sr_coupling_scheduler: shares one coupling engine across N_CH pairs.
// In: clk_en strobe, omega_osc/omega_sr, cfg_*. Out: detuning, coupling,
// lock, frame_valid pulse, busy, saturating overrun_cnt.
module sr_coupling_scheduler
  import sr_coupling_pkg::*;
#(
  parameter int N_CH = 5,
  parameter int WIDTH = 18,
  parameter int LOCK_LEVEL = 8192,
  parameter int LOCK_FRAMES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic [N_CH*WIDTH-1:0] omega_osc,
  input  logic [N_CH*WIDTH-1:0] omega_sr,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_addr,
  input  logic [WIDTH-1:0]      cfg_thresh,
  input  logic [WIDTH-1:0]      cfg_scale,
  output logic [N_CH*WIDTH-1:0] detuning,
  output logic [N_CH*WIDTH-1:0] coupling,
  output logic [N_CH-1:0]       lock,
  output logic                  frame_valid,
  output logic                  busy,
  output logic [7:0]            overrun_cnt
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int LW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);
  localparam logic [LW-1:0] LFULL = LW'(LOCK_FRAMES);

  state_t state, state_n;
  phase_t phase, phase_n;
  logic [CW-1:0] ch, ch_n;
  logic accept, en_diff, en_sq, en_scale, wr_slot, pub;
  logic cfg_ok;

  logic [WIDTH-1:0] thresh_r [N_CH];
  logic [WIDTH-1:0] scale_r [N_CH];
  logic [WIDTH-1:0] thresh_s [N_CH];
  logic [WIDTH-1:0] scale_s [N_CH];
  logic signed [WIDTH-1:0] osc_s [N_CH];
  logic signed [WIDTH-1:0] sr_s [N_CH];
  logic [WIDTH-1:0] sh_det [N_CH];
  logic [WIDTH-1:0] sh_c [N_CH];
  logic [LW-1:0] cnt [N_CH];
  logic [LW-1:0] cnt_n [N_CH];
  logic [WIDTH-1:0] eng_det, eng_c;

  assign busy = (state != IDLE);
  assign cfg_ok = int'(cfg_addr) < N_CH;

  coupling_engine #(.WIDTH(WIDTH)) u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_diff  (en_diff),
    .en_sq    (en_sq),
    .en_scale (en_scale),
    .osc      (osc_s[ch]),
    .sr       (sr_s[ch]),
    .thresh   (thresh_s[ch]),
    .scale    (scale_s[ch]),
    .det      (eng_det),
    .c        (eng_c)
  );

  always_comb begin
    state_n = state;
    phase_n = phase;
    ch_n = ch;
    accept = 1'b0;
    en_diff = 1'b0;
    en_sq = 1'b0;
    en_scale = 1'b0;
    wr_slot = 1'b0;
    pub = 1'b0;
    unique case (state)
      IDLE: begin
        if (clk_en) begin
          accept = 1'b1;
          state_n = EVAL;
          phase_n = DIFF;
          ch_n = '0;
        end
      end
      EVAL: begin
        unique case (phase)
          DIFF: begin
            en_diff = 1'b1;
            phase_n = SQ;
          end
          SQ: begin
            en_sq = 1'b1;
            phase_n = SCALE;
          end
          SCALE: begin
            en_scale = 1'b1;
            phase_n = CLAMP;
          end
          CLAMP: begin
            wr_slot = 1'b1;
            phase_n = DIFF;
            if (ch == LAST) state_n = PUBLISH;
            else ch_n = ch + CW'(1);
          end
          default: phase_n = DIFF;
        endcase
      end
      PUBLISH: begin
        pub = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_n[i] = '0;
      if (sh_c[i] >= WIDTH'(LOCK_LEVEL))
        cnt_n[i] = (cnt[i] == LFULL) ? cnt[i]
                                     : cnt[i] + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= DIFF;
      ch <= '0;
      overrun_cnt <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      ch <= ch_n;
      // strobes while busy or publishing are dropped
      if (clk_en && state != IDLE && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        thresh_r[i] <= WIDTH'(DEFAULT_THRESH);
        scale_r[i] <= WIDTH'(DEFAULT_SCALE);
      end
    end else if (cfg_we && cfg_ok) begin
      thresh_r[cfg_addr[CW-1:0]] <= cfg_thresh;
      scale_r[cfg_addr[CW-1:0]] <= cfg_scale;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        thresh_s[i] <= '0;
        scale_s[i] <= '0;
        osc_s[i] <= '0;
        sr_s[i] <= '0;
        sh_det[i] <= '0;
        sh_c[i] <= '0;
        cnt[i] <= '0;
      end
      detuning <= '0;
      coupling <= '0;
      lock <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= pub;
      if (accept) begin
        for (int i = 0; i < N_CH; i++) begin
          thresh_s[i] <= thresh_r[i];
          scale_s[i] <= scale_r[i];
          osc_s[i] <= omega_osc[i*WIDTH +: WIDTH];
          sr_s[i] <= omega_sr[i*WIDTH +: WIDTH];
        end
      end
      if (wr_slot) begin
        sh_det[ch] <= eng_det;
        sh_c[ch] <= eng_c;
      end
      if (pub) begin
        for (int i = 0; i < N_CH; i++) begin
          detuning[i*WIDTH +: WIDTH] <= sh_det[i];
          coupling[i*WIDTH +: WIDTH] <= sh_c[i];
          cnt[i] <= cnt_n[i];
          lock[i] <= (cnt_n[i] == LFULL);
        end
      end
    end
  end

endmodule
